// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: memory-wait FSM states,
// forwarding-select codes and the register-index width.
package hazard_pkg;

    localparam int REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_MEM_ERR  = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // Register $0 is hard-wired to zero, so a write to it never creates a dependency.
    function automatic logic regMatch(input logic we, input logic [REG_W-1:0] dst,
                                      input logic [REG_W-1:0] src);
        return we && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_memwait_fsm.sv
// Data-memory wait sequencer: freezes the pipeline while an M-stage access is
// outstanding and latches a sticky error after TIMEOUT_CYC unanswered wait cycles.
module hazard_memwait_fsm #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_mem_req,
    input  logic i_mem_ready,
    output logic o_mem_stall,
    output logic o_mem_err
);
    import hazard_pkg::*;

    localparam logic [9:0] LAST_WAIT = 10'(TIMEOUT_CYC - 1);

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_wait_cnt;
    logic       r_mem_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_RUN;
        else        r_state <= w_next;
    end

    // Stall release is combinational: the cycle that sees mem_ready already runs.
    always_comb begin
        w_next      = r_state;
        o_mem_stall = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_mem_req && !i_mem_ready) begin
                    w_next      = ST_MEM_WAIT;
                    o_mem_stall = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (i_mem_ready) begin
                    w_next = ST_RUN;
                end else begin
                    o_mem_stall = 1'b1;
                    if (r_wait_cnt == LAST_WAIT) w_next = ST_MEM_ERR;
                end
            end
            ST_MEM_ERR: o_mem_stall = 1'b1;
            default:    w_next      = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            if (r_state == ST_RUN && w_next == ST_MEM_WAIT) r_wait_cnt <= '0;
            else if (r_state == ST_MEM_WAIT)                r_wait_cnt <= r_wait_cnt + 10'd1;
            if (w_next == ST_MEM_ERR) r_mem_err <= 1'b1;
        end
    end

    assign o_mem_err = r_mem_err;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stage enables/flushes, forwarding selects and memory wait.
// Optional stall-cycle counter port o_stall_cnt is built when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] i_rsD,
    input  logic [4:0] i_rtD,
    input  logic       i_branchD,
    input  logic       i_pcsrcD,
    input  logic [4:0] i_rsE,
    input  logic [4:0] i_rtE,
    input  logic [4:0] i_writeregE,
    input  logic [4:0] i_writeregM,
    input  logic [4:0] i_writeregW,
    input  logic       i_RegwriteE,
    input  logic       i_RegwriteM,
    input  logic       i_RegwriteW,
    input  logic       i_MemtoregE,
    input  logic       i_MemtoregM,
    input  logic       i_mem_req,
    input  logic       i_mem_ready,
    output logic       o_enF,
    output logic       o_enD,
    output logic       o_enE,
    output logic       o_enM,
    output logic       o_flushD,
    output logic       o_flushE,
    output logic       o_flushW,
    output logic [1:0] o_forwardAE,
    output logic [1:0] o_forwardBE,
    output logic       o_forwardAD,
    output logic       o_forwardBD,
    output logic       o_mem_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] o_stall_cnt
`endif
);
    import hazard_pkg::*;

    logic w_mem_stall;
    logic w_load_use;
    logic w_branch_haz;

    hazard_memwait_fsm #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_memwait (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_mem_req   (i_mem_req),
        .i_mem_ready (i_mem_ready),
        .o_mem_stall (w_mem_stall),
        .o_mem_err   (o_mem_err)
    );

    assign w_load_use = i_MemtoregE &&
                        (regMatch(i_RegwriteE, i_writeregE, i_rsD) ||
                         regMatch(i_RegwriteE, i_writeregE, i_rtD));

    // A D-stage branch compares operands now, so it must wait on any E result or an M load.
    assign w_branch_haz = i_branchD &&
                          (regMatch(i_RegwriteE, i_writeregE, i_rsD) ||
                           regMatch(i_RegwriteE, i_writeregE, i_rtD) ||
                           regMatch(i_MemtoregM, i_writeregM, i_rsD) ||
                           regMatch(i_MemtoregM, i_writeregM, i_rtD));

    always_comb begin
        o_enF       = 1'b1;
        o_enD       = 1'b1;
        o_enE       = 1'b1;
        o_enM       = 1'b1;
        o_flushD    = 1'b0;
        o_flushE    = 1'b0;
        o_flushW    = 1'b0;
        o_forwardAE = FWD_RF;
        o_forwardBE = FWD_RF;
        o_forwardAD = 1'b0;
        o_forwardBD = 1'b0;
        if (rst_n) begin
            if (w_mem_stall) begin
                o_enF    = 1'b0;
                o_enD    = 1'b0;
                o_enE    = 1'b0;
                o_enM    = 1'b0;
                o_flushW = 1'b1;
            end else if (w_load_use || w_branch_haz) begin
                o_enF    = 1'b0;
                o_enD    = 1'b0;
                o_flushE = 1'b1;
            end else if (i_pcsrcD) begin
                o_flushD = 1'b1;
            end

            if (regMatch(i_RegwriteM, i_writeregM, i_rsE))      o_forwardAE = FWD_M;
            else if (regMatch(i_RegwriteW, i_writeregW, i_rsE)) o_forwardAE = FWD_W;
            if (regMatch(i_RegwriteM, i_writeregM, i_rtE))      o_forwardBE = FWD_M;
            else if (regMatch(i_RegwriteW, i_writeregW, i_rtE)) o_forwardBE = FWD_W;
            o_forwardAD = regMatch(i_RegwriteM, i_writeregM, i_rsD);
            o_forwardBD = regMatch(i_RegwriteM, i_writeregM, i_rtD);
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                 r_stall_cnt <= '0;
        else if (!o_enF && r_stall_cnt != 32'hFFFF_FFFF) r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign o_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: table vectors, hand-written multi-cycle
// sequences and randomized stimulus against a behavioural reference model.
module tb_hazard_ctrl;

    localparam int TMO = 4;

    typedef struct packed {
        logic [4:0] rsD, rtD;
        logic       branchD, pcsrcD;
        logic [4:0] rsE, rtE, wE, wM, wW;
        logic       rwE, rwM, rwW, mtrE, mtrM, req, rdy;
    } in_t;

    typedef struct packed {
        logic [3:0] en;
        logic [2:0] fl;
        logic [1:0] fAE, fBE;
        logic       fAD, fBD;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  drv = '0;

    logic       enF, enD, enE, enM, flushD, flushE, flushW, fAD, fBD, memErr;
    logic [1:0] fAE, fBE;
    logic [31:0] stallCnt;

    int total = 0;
    int bad = 0;

    bit      mWaiting;
    int      mWaited;
    bit      mErr;
    longint  mStallCnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rsD       (drv.rsD),
        .i_rtD       (drv.rtD),
        .i_branchD   (drv.branchD),
        .i_pcsrcD    (drv.pcsrcD),
        .i_rsE       (drv.rsE),
        .i_rtE       (drv.rtE),
        .i_writeregE (drv.wE),
        .i_writeregM (drv.wM),
        .i_writeregW (drv.wW),
        .i_RegwriteE (drv.rwE),
        .i_RegwriteM (drv.rwM),
        .i_RegwriteW (drv.rwW),
        .i_MemtoregE (drv.mtrE),
        .i_MemtoregM (drv.mtrM),
        .i_mem_req   (drv.req),
        .i_mem_ready (drv.rdy),
        .o_enF       (enF),
        .o_enD       (enD),
        .o_enE       (enE),
        .o_enM       (enM),
        .o_flushD    (flushD),
        .o_flushE    (flushE),
        .o_flushW    (flushW),
        .o_forwardAE (fAE),
        .o_forwardBE (fBE),
        .o_forwardAD (fAD),
        .o_forwardBD (fBD),
        .o_mem_err   (memErr)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .o_stall_cnt (stallCnt)
`endif
    );

`ifndef HAZARD_PERF_CNT_EN
    assign stallCnt = '0;
`endif

    function automatic in_t mkIn(int rsD, int rtD, bit br, bit pc, int rsE, int rtE,
                                 int wE, int wM, int wW, bit rwE, bit rwM, bit rwW,
                                 bit mtrE, bit mtrM);
        in_t x = '0;
        x.rsD = 5'(rsD);  x.rtD = 5'(rtD);  x.branchD = br; x.pcsrcD = pc;
        x.rsE = 5'(rsE);  x.rtE = 5'(rtE);
        x.wE = 5'(wE);    x.wM = 5'(wM);    x.wW = 5'(wW);
        x.rwE = rwE; x.rwM = rwM; x.rwW = rwW; x.mtrE = mtrE; x.mtrM = mtrM;
        return x;
    endfunction

    function automatic out_t mkOut(logic [3:0] en, logic [2:0] fl, logic [1:0] a,
                                   logic [1:0] b, logic ad, logic bd);
        out_t o;
        o.en = en; o.fl = fl; o.fAE = a; o.fBE = b; o.fAD = ad; o.fBD = bd;
        return o;
    endfunction

    function automatic bit hit(bit we, int dst, int src);
        return we && dst != 0 && dst == src;
    endfunction

    // Reference: what the pipeline must do this cycle, from the hazard rules directly.
    function automatic out_t model(in_t x);
        out_t o;
        bit memStall, needStall;
        int rsD = int'(x.rsD), rtD = int'(x.rtD), wE = int'(x.wE), wM = int'(x.wM);
        memStall  = mErr || (mWaiting ? !x.rdy : (x.req && !x.rdy));
        needStall = (x.mtrE && (hit(x.rwE, wE, rsD) || hit(x.rwE, wE, rtD))) ||
                    (x.branchD && (hit(x.rwE, wE, rsD) || hit(x.rwE, wE, rtD) ||
                                   hit(x.mtrM, wM, rsD) || hit(x.mtrM, wM, rtD)));
        o.en = 4'b1111;
        o.fl = 3'b000;
        if (memStall)       begin o.en = 4'b0000; o.fl = 3'b001; end
        else if (needStall) begin o.en = 4'b0011; o.fl = 3'b010; end
        else if (x.pcsrcD)  o.fl = 3'b100;
        o.fAE = hit(x.rwM, wM, int'(x.rsE)) ? 2'd2 : hit(x.rwW, int'(x.wW), int'(x.rsE)) ? 2'd1 : 2'd0;
        o.fBE = hit(x.rwM, wM, int'(x.rtE)) ? 2'd2 : hit(x.rwW, int'(x.wW), int'(x.rtE)) ? 2'd1 : 2'd0;
        o.fAD = hit(x.rwM, wM, rsD);
        o.fBD = hit(x.rwM, wM, rtD);
        return o;
    endfunction

    // Advance the model across one clock edge with the inputs of the cycle just checked.
    task automatic advanceModel(in_t x);
        out_t o = model(x);
        if (o.en[3] == 1'b0 && mStallCnt < 64'hFFFF_FFFF) mStallCnt++;
        if (!mErr) begin
            if (mWaiting) begin
                if (x.rdy)                   mWaiting = 0;
                else if (mWaited + 1 == TMO) mErr = 1;
                else                         mWaited++;
            end else if (x.req && !x.rdy) begin
                mWaiting = 1;
                mWaited  = 0;
            end
        end
    endtask

    task automatic clearModel();
        mWaiting = 0; mWaited = 0; mErr = 0; mStallCnt = 0;
    endtask

    task automatic applyStimulus(in_t x);
        @(negedge clk);
        drv = x;
        #1;
    endtask

    task automatic checkOutput(string name, out_t exp);
        out_t act;
        act = {enF, enD, enE, enM, flushD, flushE, flushW, fAE, fBE, fAD, fBD};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got en=%b fl=%b fAE=%b fBE=%b fAD=%b fBD=%b, want en=%b fl=%b fAE=%b fBE=%b fAD=%b fBD=%b",
                     name, act.en, act.fl, act.fAE, act.fBE, act.fAD, act.fBD,
                     exp.en, exp.fl, exp.fAE, exp.fBE, exp.fAD, exp.fBD);
        end
        total++;
        if (memErr !== mErr) begin
            bad++;
            $display("[TB] FAIL %s mem_err: got %b want %b", name, memErr, mErr);
        end
    endtask

    task automatic checkBit(string name, logic act, logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic checkStallCnt(string name);
`ifdef HAZARD_PERF_CNT_EN
        total++;
        if (stallCnt !== 32'(mStallCnt)) begin
            bad++;
            $display("[TB] FAIL %s stall_cnt: got %0d want %0d", name, stallCnt, mStallCnt);
        end
`endif
    endtask

    task automatic stepModel(string name, in_t x);
        applyStimulus(x);
        checkOutput(name, model(x));
        advanceModel(x);
    endtask

    task automatic holdReset(string name, in_t x);
        drv = x;
        rst_n = 1'b0;
        clearModel();
        #1;
        checkOutput(name, mkOut(4'b1111, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0));
        checkStallCnt(name);
    endtask

    vec_t vecs[15];
    in_t  x;

    initial begin
        clearModel();
        vecs[0]  = '{"idle",        mkIn(0,0,0,0, 0,0, 0,0,0, 0,0,0, 0,0), mkOut(4'b1111,3'b000,2'd0,2'd0,0,0)};
        vecs[1]  = '{"loaduse_rs",  mkIn(5,1,0,0, 0,0, 5,0,0, 1,0,0, 1,0), mkOut(4'b0011,3'b010,2'd0,2'd0,0,0)};
        vecs[2]  = '{"loaduse_rt",  mkIn(1,9,0,0, 0,0, 9,0,0, 1,0,0, 1,0), mkOut(4'b0011,3'b010,2'd0,2'd0,0,0)};
        vecs[3]  = '{"loaduse_r0",  mkIn(0,0,0,0, 0,0, 0,0,0, 1,0,0, 1,0), mkOut(4'b1111,3'b000,2'd0,2'd0,0,0)};
        vecs[4]  = '{"fwd_m_wins",  mkIn(0,0,0,0, 7,0, 0,7,7, 0,1,1, 0,0), mkOut(4'b1111,3'b000,2'd2,2'd0,0,0)};
        vecs[5]  = '{"fwd_w",       mkIn(0,0,0,0, 7,0, 0,0,7, 0,1,1, 0,0), mkOut(4'b1111,3'b000,2'd1,2'd0,0,0)};
        vecs[6]  = '{"fwd_zero",    mkIn(0,0,0,0, 0,0, 0,0,0, 0,1,1, 0,0), mkOut(4'b1111,3'b000,2'd0,2'd0,0,0)};
        vecs[7]  = '{"fwd_both",    mkIn(0,0,0,0, 4,3, 0,4,3, 0,1,1, 0,0), mkOut(4'b1111,3'b000,2'd2,2'd1,0,0)};
        vecs[8]  = '{"br_haz_E",    mkIn(6,0,1,0, 0,0, 6,0,0, 1,0,0, 0,0), mkOut(4'b0011,3'b010,2'd0,2'd0,0,0)};
        vecs[9]  = '{"br_haz_Mld",  mkIn(0,8,1,0, 0,0, 0,8,0, 0,1,0, 0,1), mkOut(4'b0011,3'b010,2'd0,2'd0,0,1)};
        vecs[10] = '{"pc_and_lu",   mkIn(5,0,1,1, 0,0, 5,0,0, 1,0,0, 1,0), mkOut(4'b0011,3'b010,2'd0,2'd0,0,0)};
        vecs[11] = '{"pc_taken",    mkIn(5,0,1,1, 0,0, 0,0,0, 0,0,0, 0,0), mkOut(4'b1111,3'b100,2'd0,2'd0,0,0)};
        vecs[12] = '{"fwd_AD",      mkIn(2,0,0,0, 0,0, 0,2,0, 0,1,0, 0,0), mkOut(4'b1111,3'b000,2'd0,2'd0,1,0)};
        vecs[13] = '{"br_r0_taken", mkIn(0,0,1,1, 0,0, 0,0,0, 1,0,0, 0,0), mkOut(4'b1111,3'b100,2'd0,2'd0,0,0)};
        vecs[14] = '{"lu_no_rw",    mkIn(5,0,0,0, 0,0, 5,0,0, 0,0,0, 1,0), mkOut(4'b1111,3'b000,2'd0,2'd0,0,0)};

        holdReset("reset_state", mkIn(3,3,0,1, 3,3, 3,3,3, 1,1,1, 1,1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].in);
            checkOutput(vecs[i].name, vecs[i].exp);
            advanceModel(vecs[i].in);
        end

        // Load-use: one stall cycle, then the load sits in M and forwards to E.
        stepModel("lu_seq_stall", mkIn(5,0,0,0, 0,0, 5,0,0, 1,0,0, 1,0));
        checkBit("lu_seq_enF", enF, 1'b0);
        stepModel("lu_seq_fwd",   mkIn(0,0,0,0, 5,0, 0,5,0, 0,1,0, 0,1));
        checkBit("lu_seq_fwdAE", fAE[1], 1'b1);

        // Memory access answered three cycles later.
        holdReset("rst_before_mem", '0);
        @(negedge clk); rst_n = 1'b1;
        x = '0; x.req = 1;
        for (int i = 0; i < 3; i++) begin
            stepModel("memwait_stall", x);
            checkBit("memwait_enM", enM, 1'b0);
        end
        x.rdy = 1;
        stepModel("memwait_release", x);
        checkBit("memwait_rel_enF", enF, 1'b1);
        stepModel("memwait_back_run", '0);
        checkStallCnt("memwait_cnt");

        // Timeout with mem_ready never arriving.
        x = '0; x.req = 1;
        for (int i = 0; i < 5; i++) stepModel("timeout_stall", x);
        @(negedge clk);
        checkBit("timeout_err_set", memErr, 1'b1);
        x.rdy = 1;
        for (int i = 0; i < 3; i++) stepModel("err_frozen", x);
        checkStallCnt("err_cnt");
        #2;
        holdReset("err_reset", '0);
        checkBit("err_reset_clear", memErr, 1'b0);
        @(negedge clk); rst_n = 1'b1;

        // Reset landing in the middle of a memory wait.
        x = '0; x.req = 1;
        for (int i = 0; i < 2; i++) stepModel("midwait_stall", x);
        #2;
        holdReset("midwait_reset", mkIn(4,4,1,1, 4,4, 4,4,4, 1,1,1, 1,1));
        @(posedge clk); #1;
        checkOutput("midwait_reset_held", mkOut(4'b1111,3'b000,2'd0,2'd0,0,0));
        @(negedge clk); rst_n = 1'b1;
        stepModel("midwait_after", '0);
        checkBit("midwait_run_enF", enF, 1'b1);

        // Randomized traffic with periodic resets to escape the error state.
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 49) begin
                holdReset("rnd_reset", '0);
                @(negedge clk); rst_n = 1'b1;
            end
            x.rsD = 5'($urandom_range(0, 3));   x.rtD = 5'($urandom_range(0, 3));
            x.rsE = 5'($urandom_range(0, 3));   x.rtE = 5'($urandom_range(0, 3));
            x.wE  = 5'($urandom_range(0, 3));   x.wM  = 5'($urandom_range(0, 3));
            x.wW  = 5'($urandom_range(0, 3));
            x.branchD = 1'($urandom); x.pcsrcD = 1'($urandom);
            x.rwE = 1'($urandom); x.rwM = 1'($urandom); x.rwW = 1'($urandom);
            x.mtrE = 1'($urandom); x.mtrM = 1'($urandom);
            x.req = ($urandom_range(0, 9) < 3);
            x.rdy = 1'($urandom);
            stepModel("random", x);
            if (i % 25 == 0) checkStallCnt("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage core. It drives the enable and flush inputs of the F/D/E/M/W pipeline registers and generates forwarding selects. It detects load-use and branch-operand hazards and sequences a multi-cycle data-memory wait with timeout. It sits beside the datapath and owns every `en*` and flush line of the inter-stage registers.

## Interface
- `TIMEOUT_CYC`, 255: max `mem_ready` wait cycles before error (1..1023).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rsD`, `rtD` in 5 each: decode-stage source registers.
- `branchD` in 1: decode holds a branch (resolved in D).
- `pcsrcD` in 1: branch taken in D.
- `rsE`, `rtE` in 5 each: execute-stage source registers.
- `writeregE`, `writeregM`, `writeregW` in 5 each: destination register per stage.
- `RegwriteE`, `RegwriteM`, `RegwriteW` in 1 each: stage writes the register file.
- `MemtoregE`, `MemtoregM` in 1 each: stage is a load.
- `mem_req` in 1: M-stage access active this cycle.
- `mem_ready` in 1: data memory completes the access this cycle.
- `enF`, `enD`, `enE`, `enM` out 1 each: pipeline register enables (1 = load).
- `flushD`, `flushE`, `flushW` out 1 each: load a bubble (all-zero control) into the register.
- `forwardAE`, `forwardBE` out 2 each: 00 = regfile, 01 = W result, 10 = M result.
- `forwardAD`, `forwardBD` out 1 each: branch comparator takes the M result.
- `mem_err` out 1: sticky memory timeout flag.
- `stall_cnt` out 32: stall cycle count (only with macro).

## Operation
- FSM states: RUN, MEM_WAIT, MEM_ERR.
  - RUN -> MEM_WAIT when `mem_req && !mem_ready`.
  - MEM_WAIT -> RUN on `mem_ready`.
  - MEM_WAIT -> MEM_ERR when `wait_cnt == TIMEOUT_CYC-1` and `!mem_ready`.
  - MEM_ERR is left only by reset.
- Memory stall, active in (RUN with `mem_req && !mem_ready`) or MEM_WAIT without `mem_ready`, or MEM_ERR:
  - `enF`, `enD`, `enE`, `enM` = 0.
  - `flushW` = 1.
  - All other flushes = 0.
- Load-use hazard:
  - Condition: `MemtoregE && RegwriteE && writeregE != 0 && (writeregE == rsD || writeregE == rtD)`.
  - Response: `enF` = `enD` = 0, `flushE` = 1.
- Branch hazard:
  - Condition: `branchD` and either (`RegwriteE && writeregE != 0` matching `rsD`/`rtD`) or (`MemtoregM` with `writeregM` matching `rsD`/`rtD`).
  - Response: same as load-use.
- Taken branch: `pcsrcD && no stall` -> `flushD` = 1.
- Priority: memory stall > load-use/branch stall > taken-branch flush. A lower-priority action is suppressed while a higher one is active.
- Forwarding, computed in every state:
  - `forwardAE` = 10 if `RegwriteM && writeregM != 0 && writeregM == rsE`; else 01 if the same test passes against W; else 00. M wins over W.
  - `forwardBE`: same rule using `rtE`.
  - `forwardAD` = `RegwriteM && writeregM != 0 && writeregM == rsD`. `forwardBD` uses `rtD`.
- Register $0 never matches.
- `wait_cnt` is 10 bits. It clears on entry to MEM_WAIT and increments each MEM_WAIT cycle.

## Timing
- Hazard detection and forwarding are combinational from the inputs and state, with zero-cycle latency.
- A load-use stall lasts exactly 1 cycle; the next cycle's inputs carry the bubble in E.
- `mem_ready` in the same cycle as `mem_req` causes no stall. Otherwise the stall length equals the number of cycles until `mem_ready`.
- In the MEM_WAIT cycle where `mem_ready` = 1, enables are already 1 (release is combinational). The state returns to RUN at the next edge.
- `mem_err` is registered and rises on the edge that enters MEM_ERR.
- Reset (asynchronous, any time, including mid-MEM_WAIT):
  - state = RUN, `wait_cnt` = 0, `mem_err` = 0, `stall_cnt` = 0.
  - While `rst_n` = 0 outputs are forced: all `en*` = 1, all `flush*` = 0, all forwards = 0.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` is present.
  - It increments each cycle with `enF` = 0, saturates at 0xFFFFFFFF, and clears only on reset.
- `HAZARD_PERF_CNT_EN` not defined: the `stall_cnt` port and its logic are omitted.

## Structure
- Shared package `hazard_pkg`:
  - state encoding: RUN = 0, MEM_WAIT = 1, MEM_ERR = 2.
  - forward-select constants `FWD_RF`, `FWD_W`, `FWD_M`.
  - register-index width of 5.
- Sub-module `hazard_memwait_fsm`:
  - contains the FSM, `wait_cnt` and `mem_err`.
  - outputs `mem_stall`.
- The top level holds the comparators, priority logic and the optional counter.

## Test plan
- Load `$5` in E, `rsD` = 5 -> one cycle of `enF` = `enD` = 0, `flushE` = 1; next cycle `forwardAE` = 10 once the load is in M.
- `writeregM` = `writeregW` = 7, both writing, `rsE` = 7 -> `forwardAE` = 10. Then `writeregM` = 0 -> `forwardAE` = 01. All-zero destinations -> 00.
- `mem_req`, `mem_ready` delayed 3 cycles -> 3 cycles of all `en*` = 0 and `flushW` = 1; state returns to RUN; `stall_cnt` += 3 with the macro.
- `TIMEOUT_CYC` = 4, `mem_ready` never asserted -> `mem_err` rises after 5 stalled cycles (1 RUN + 4 MEM_WAIT) and the pipeline stays frozen. Asserting `rst_n` = 0 clears it immediately.
- `pcsrcD` = 1 together with a load-use hazard -> stall only, `flushD` = 0. Next cycle `pcsrcD` = 1 with no hazard -> `flushD` = 1.
- Reset asserted mid-MEM_WAIT -> asynchronous return to RUN, with `en*` = 1 while reset is held.
